bram_stream_writer: RTL and testbench
=====================================

// Module: bram_stream_writer
// PURPOSE
//   AXI-Stream slave that receives one lattice frame (DEPTH pixels, 9 D2Q9 directions
//   per pixel, 16 bits each) and writes each pixel into the per-direction BRAMs.
//   Receive-side counterpart of the BRAM read/stream controller; used to load initial
//   or host-updated distributions into the LBM core's lattice memory.
// PARAMETERS
//   DATA_WIDTH     16    width of one direction value
//   DEPTH          2500  pixels per frame (BRAM depth)
//   ADDRESS_WIDTH  12    BRAM address width; must satisfy 2**ADDRESS_WIDTH >= DEPTH
// PORTS
//   clk           in   1               system clock, all logic on rising edge
//   rst           in   1               asynchronous, active-high reset
//   frame_start   in   1               1-cycle pulse: arm reception of one frame
//   s_tdata       in   9*DATA_WIDTH    pixel beat {n,null,ne,e,se,s,sw,w,nw}, n in MSBs
//   s_tvalid      in   1               beat valid
//   s_tready      out  1               block can accept a beat
//   s_tlast       in   1               last beat of frame
//   s_tkeep       in   9*DATA_WIDTH/8  byte enables; must be all ones
//   wr_en         out  1               BRAM write strobe (all 9 BRAMs)
//   wr_addr       out  ADDRESS_WIDTH   BRAM write address = pixel index
//   wr_n..wr_nw   out  DATA_WIDTH x9   wr_n,wr_null,wr_ne,wr_e,wr_se,wr_s,wr_sw,wr_w,wr_nw
//   busy          out  1               high in RECV or DRAIN
//   frame_done    out  1               1-cycle pulse: frame completed without length error
//   err_short     out  1               sticky: tlast before pixel DEPTH-1
//   err_long      out  1               sticky: no tlast on pixel DEPTH-1
//   err_keep      out  1               sticky: beat received with tkeep != all ones
//   frame_count   out  16              frames completed with frame_done, wraps at 2**16
// BEHAVIOUR
//   Reset: state IDLE; s_tready, wr_en, busy, frame_done, err_* = 0; wr_addr, wr_* data,
//     pixel index, frame_count = 0.
//   Accept = s_tvalid & s_tready. s_tready is a registered function of state only
//     (1 in RECV and DRAIN, 0 in IDLE); never depends combinationally on s_tvalid.
//   IDLE: s_tready=0. frame_start -> RECV; pixel index <= 0; err_* cleared.
//   RECV: each accept with tkeep all ones: next cycle wr_en=1, wr_addr=pixel index,
//     wr_* = tdata slices (latency 1, registered). tkeep partial: no write, err_keep<=1,
//     index still advances (address alignment preserved). Index increments per accept.
//     - accept at index DEPTH-1 with tlast: frame_done=1 in the same cycle as that
//       beat's wr_en; frame_count+1; -> IDLE.
//     - accept with tlast at index < DEPTH-1: beat written, err_short<=1, no frame_done,
//       -> IDLE.
//     - accept at index DEPTH-1 without tlast: beat written, err_long<=1, -> DRAIN.
//   DRAIN: s_tready=1, beats discarded (wr_en=0) until an accept with tlast -> IDLE.
//   frame_start while busy is ignored. s_tvalid while IDLE is not accepted (stalls).
//   Index never exceeds DEPTH-1; wr_addr wraps only via frame_start re-arm.
//   wr_en is a single-cycle strobe per accepted beat; back-to-back accepts give
//   back-to-back writes at consecutive addresses, no bubbles.
//   rst asserted mid-frame: immediate return to reset values; partial frame abandoned,
//   BRAM contents already written are left as is.
// TESTING
//   DEPTH=8: frame_start, 8 beats tvalid=1 every cycle, tlast on 8th -> wr_en 8 cycles,
//     wr_addr 0..7, data matches slices, frame_done with addr 7, frame_count=1.
//   DEPTH=8: random tvalid gaps (~50%) -> same writes in order, no duplicates, no bubbles
//     at accepted beats, frame_done once.
//   DEPTH=8: tlast on 5th beat -> 5 writes (addr 0..4), err_short=1, no frame_done, IDLE;
//     next frame_start clears err_short.
//   DEPTH=8: no tlast, 11 beats with tlast on 11th -> 8 writes, err_long=1, beats 9-11
//     accepted but not written, returns IDLE; tkeep=0x0FFFF on beat 3 -> no write at
//     addr 2, err_keep=1, beat 4 writes addr 3.
//   Before frame_start, tvalid=1 -> s_tready=0, wr_en never 1; rst pulse during beat 4 of
//     default DEPTH=2500 frame -> all outputs at reset values on next edge, frame_count=0.

Source files
------------

// File: rtl/bram_stream_writer.sv
// bram_stream_writer
// AXI-Stream slave that loads one lattice frame into the nine per-direction
// BRAMs of the LBM core. Each beat carries one pixel. The beat is written at
// the address equal to its pixel index, one cycle after it is accepted.
// Length errors (short or long frame) and byte-enable errors are reported on
// sticky flags. The flags are cleared on the next frame_start.

module bram_stream_writer #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [9*DATA_WIDTH-1:0]    s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  input  logic [9*DATA_WIDTH/8-1:0]  s_tkeep,
  output logic                       wr_en,
  output logic [ADDRESS_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_n,
  output logic [DATA_WIDTH-1:0]      wr_null,
  output logic [DATA_WIDTH-1:0]      wr_ne,
  output logic [DATA_WIDTH-1:0]      wr_e,
  output logic [DATA_WIDTH-1:0]      wr_se,
  output logic [DATA_WIDTH-1:0]      wr_s,
  output logic [DATA_WIDTH-1:0]      wr_sw,
  output logic [DATA_WIDTH-1:0]      wr_w,
  output logic [DATA_WIDTH-1:0]      wr_nw,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err_short,
  output logic                       err_long,
  output logic                       err_keep,
  output logic [15:0]                frame_count
);

  // state | meaning
  // IDLE  | waiting for frame_start, stream stalled
  // RECV  | accepting and writing pixels 0..DEPTH-1
  // DRAIN | frame overran DEPTH, discarding beats until tlast
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [ADDRESS_WIDTH-1:0] pix_idx;
  logic                     accept;
  logic                     keep_ok;
  logic                     at_last;

  assign accept  = s_tvalid & s_tready;
  assign keep_ok = &s_tkeep;
  assign at_last = (pix_idx == LAST_IDX);

  // Next-state decode. s_tready and busy are registered from this value, so
  // they depend only on the state, never combinationally on s_tvalid.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (frame_start) state_nxt = ST_IDLE + 2'd1;
      ST_RECV: begin
        if (accept) begin
          if (s_tlast)      state_nxt = ST_IDLE;
          else if (at_last) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (accept && s_tlast) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Frame control: state, pixel index, status flags and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      s_tready    <= 1'b0;
      busy        <= 1'b0;
      pix_idx     <= '0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_keep    <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      state      <= state_nxt;
      s_tready   <= (state_nxt != ST_IDLE);
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            pix_idx   <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_keep  <= 1'b0;
          end
        end
        ST_RECV: begin
          if (accept) begin
            if (!keep_ok) err_keep <= 1'b1;
            // The index stays at DEPTH-1 so that a frame can never address past the BRAM.
            if (!at_last) pix_idx <= pix_idx + ADDRESS_WIDTH'(1);
            if (s_tlast && at_last) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end
            if (s_tlast && !at_last) err_short <= 1'b1;
            if (!s_tlast && at_last) err_long  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // BRAM write port: registered strobe, address and direction slices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_n    <= '0;
      wr_null <= '0;
      wr_ne   <= '0;
      wr_e    <= '0;
      wr_se   <= '0;
      wr_s    <= '0;
      wr_sw   <= '0;
      wr_w    <= '0;
      wr_nw   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (state == ST_RECV && accept && keep_ok) begin
        wr_en   <= 1'b1;
        wr_addr <= pix_idx;
        wr_n    <= s_tdata[8*DATA_WIDTH +: DATA_WIDTH];
        wr_null <= s_tdata[7*DATA_WIDTH +: DATA_WIDTH];
        wr_ne   <= s_tdata[6*DATA_WIDTH +: DATA_WIDTH];
        wr_e    <= s_tdata[5*DATA_WIDTH +: DATA_WIDTH];
        wr_se   <= s_tdata[4*DATA_WIDTH +: DATA_WIDTH];
        wr_s    <= s_tdata[3*DATA_WIDTH +: DATA_WIDTH];
        wr_sw   <= s_tdata[2*DATA_WIDTH +: DATA_WIDTH];
        wr_w    <= s_tdata[1*DATA_WIDTH +: DATA_WIDTH];
        wr_nw   <= s_tdata[0*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_writer.sv
// Directed testbench for bram_stream_writer: a DEPTH=8 instance for the frame
// scenarios and a default DEPTH=2500 instance for a full frame and a reset
// that arrives partway through a frame.

module tb_bram_stream_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- small instance (DEPTH = 8) ----------------
  logic         rst, frame_start, s_tvalid, s_tready, s_tlast;
  logic [143:0] s_tdata;
  logic [17:0]  s_tkeep;
  logic         wr_en, busy, frame_done, err_short, err_long, err_keep;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_n, wr_null, wr_ne, wr_e, wr_se, wr_s, wr_sw, wr_w, wr_nw;
  logic [15:0]  frame_count;

  bram_stream_writer #(.DATA_WIDTH(16), .DEPTH(8), .ADDRESS_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tkeep(s_tkeep),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_n(wr_n), .wr_null(wr_null), .wr_ne(wr_ne), .wr_e(wr_e), .wr_se(wr_se),
    .wr_s(wr_s), .wr_sw(wr_sw), .wr_w(wr_w), .wr_nw(wr_nw),
    .busy(busy), .frame_done(frame_done), .err_short(err_short),
    .err_long(err_long), .err_keep(err_keep), .frame_count(frame_count)
  );

  // ---------------- big instance (default DEPTH = 2500) ----------------
  logic         b_rst, b_frame_start, b_s_tvalid, b_s_tready, b_s_tlast;
  logic [143:0] b_s_tdata;
  logic [17:0]  b_s_tkeep;
  logic         b_wr_en, b_busy, b_frame_done, b_err_short, b_err_long, b_err_keep;
  logic [11:0]  b_wr_addr;
  logic [15:0]  b_wr_n, b_wr_null, b_wr_ne, b_wr_e, b_wr_se, b_wr_s, b_wr_sw, b_wr_w, b_wr_nw;
  logic [15:0]  b_frame_count;

  bram_stream_writer big (
    .clk(clk), .rst(b_rst), .frame_start(b_frame_start),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
    .s_tlast(b_s_tlast), .s_tkeep(b_s_tkeep),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_n(b_wr_n), .wr_null(b_wr_null), .wr_ne(b_wr_ne), .wr_e(b_wr_e), .wr_se(b_wr_se),
    .wr_s(b_wr_s), .wr_sw(b_wr_sw), .wr_w(b_wr_w), .wr_nw(b_wr_nw),
    .busy(b_busy), .frame_done(b_frame_done), .err_short(b_err_short),
    .err_long(b_err_long), .err_keep(b_err_keep), .frame_count(b_frame_count)
  );

  // Write monitors, sampled on the falling edge.
  logic [3:0]   w_addr[$];
  logic [143:0] w_data[$];
  logic         w_fd[$];
  int           w_cyc[$];
  int           a_cyc[$];
  int           fd_cnt;

  always @(negedge clk) begin
    if (wr_en) begin
      w_addr.push_back(wr_addr);
      w_data.push_back({wr_n, wr_null, wr_ne, wr_e, wr_se, wr_s, wr_sw, wr_w, wr_nw});
      w_fd.push_back(frame_done);
      w_cyc.push_back(cyc);
    end
    if (frame_done) fd_cnt++;
  end

  int          b_wr_cnt = 0;
  int          b_fd_cnt = 0;
  logic [11:0] b_fd_addr = '0;
  always @(negedge clk) begin
    if (b_wr_en) b_wr_cnt++;
    if (b_frame_done) begin
      b_fd_cnt++;
      b_fd_addr = b_wr_addr;
    end
  end

  // Beat payload: each 16-bit direction slice = f*256 + b*16 + dir (dir 0 = nw in the LSBs).
  function automatic logic [143:0] mk(input int f, input int b);
    logic [143:0] r;
    for (int d = 0; d < 9; d++) r[d*16 +: 16] = 16'(f*256 + b*16 + d);
    return r;
  endfunction

  task automatic clear_log();
    w_addr.delete(); w_data.delete(); w_fd.delete(); w_cyc.delete();
    a_cyc.delete(); fd_cnt = 0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Present one beat from a falling edge and hold it until it is accepted.
  task automatic send_beat(input logic [143:0] d, input logic last, input logic [17:0] keep);
    int  n = 0;
    bit  done = 0;
    s_tdata = d; s_tlast = last; s_tkeep = keep; s_tvalid = 1'b1;
    while (!done) begin
      if (s_tready) done = 1;
      @(negedge clk);
      if (done) a_cyc.push_back(cyc);
      n++;
      if (!done && n > 50) begin
        nchk++; nfail++;
        $display("FAIL beat_accept_timeout: s_tready stayed %b, required 1", s_tready);
        done = 1;
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic test_reset();
    nchk++; if (s_tready !== 1'b0)     begin nfail++; $display("FAIL rst_tready: got %b want 0", s_tready); end
    nchk++; if (wr_en !== 1'b0)        begin nfail++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    nchk++; if (busy !== 1'b0)         begin nfail++; $display("FAIL rst_busy: got %b want 0", busy); end
    nchk++; if (frame_done !== 1'b0)   begin nfail++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    nchk++; if ({err_short, err_long, err_keep} !== 3'b000)
      begin nfail++; $display("FAIL rst_err: got %b want 000", {err_short, err_long, err_keep}); end
    nchk++; if (wr_addr !== 4'd0)      begin nfail++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    nchk++; if ({wr_n, wr_null, wr_ne, wr_e, wr_se, wr_s, wr_sw, wr_w, wr_nw} !== 144'd0)
      begin nfail++; $display("FAIL rst_wr_data: got nonzero want 0"); end
    nchk++; if (frame_count !== 16'd0) begin nfail++; $display("FAIL rst_frame_count: got %0d want 0", frame_count); end
  endtask

  task automatic test_idle_stall();
    clear_log();
    s_tdata = mk(9, 9); s_tkeep = '1; s_tlast = 1'b1; s_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nchk++; if (s_tready !== 1'b0) begin nfail++; $display("FAIL idle_tready: cycle %0d got %b want 0", i, s_tready); end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (2) @(negedge clk);
    nchk++; if (w_addr.size() !== 0) begin nfail++; $display("FAIL idle_writes: got %0d want 0", w_addr.size()); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_frame();
    clear_log();
    pulse_start();
    nchk++; if (s_tready !== 1'b1) begin nfail++; $display("FAIL full_tready_after_start: got %b want 1", s_tready); end
    for (int b = 0; b < 8; b++) send_beat(mk(1, b), b == 7, '1);
    repeat (2) @(negedge clk);
    nchk++; if (w_addr.size() !== 8) begin nfail++; $display("FAIL full_write_count: got %0d want 8", w_addr.size()); end
    for (int i = 0; i < 8 && i < w_addr.size(); i++) begin
      nchk++; if (w_addr[i] !== 4'(i))  begin nfail++; $display("FAIL full_addr[%0d]: got %0d want %0d", i, w_addr[i], i); end
      nchk++; if (w_data[i] !== mk(1, i)) begin nfail++; $display("FAIL full_data[%0d]: got %h want %h", i, w_data[i], mk(1, i)); end
      nchk++; if (w_cyc[i] !== a_cyc[0] + i) begin nfail++; $display("FAIL full_write_cycle[%0d]: got %0d want %0d", i, w_cyc[i], a_cyc[0] + i); end
      nchk++; if (w_fd[i] !== (i == 7)) begin nfail++; $display("FAIL full_done_with_write[%0d]: got %b want %b", i, w_fd[i], i == 7); end
    end
    nchk++; if (fd_cnt !== 1) begin nfail++; $display("FAIL full_done_count: got %0d want 1", fd_cnt); end
    nchk++; if (frame_count !== 16'd1) begin nfail++; $display("FAIL full_frame_count: got %0d want 1", frame_count); end
    nchk++; if ({busy, s_tready} !== 2'b00) begin nfail++; $display("FAIL full_back_idle: busy/tready %b want 00", {busy, s_tready}); end
    nchk++; if ({err_short, err_long, err_keep} !== 3'b000)
      begin nfail++; $display("FAIL full_err: got %b want 000", {err_short, err_long, err_keep}); end
  endtask

  task automatic test_gaps();
    int gaps[8] = '{1, 0, 2, 1, 0, 3, 0, 1};
    clear_log();
    pulse_start();
    for (int b = 0; b < 8; b++) begin
      repeat (gaps[b]) @(negedge clk);
      send_beat(mk(2, b), b == 7, '1);
    end
    repeat (2) @(negedge clk);
    nchk++; if (w_addr.size() !== 8) begin nfail++; $display("FAIL gaps_write_count: got %0d want 8", w_addr.size()); end
    for (int i = 0; i < 8 && i < w_addr.size(); i++) begin
      nchk++; if (w_addr[i] !== 4'(i))  begin nfail++; $display("FAIL gaps_addr[%0d]: got %0d want %0d", i, w_addr[i], i); end
      nchk++; if (w_data[i] !== mk(2, i)) begin nfail++; $display("FAIL gaps_data[%0d]: got %h want %h", i, w_data[i], mk(2, i)); end
      nchk++; if (w_cyc[i] !== a_cyc[i]) begin nfail++; $display("FAIL gaps_write_cycle[%0d]: got %0d want %0d", i, w_cyc[i], a_cyc[i]); end
    end
    nchk++; if (fd_cnt !== 1) begin nfail++; $display("FAIL gaps_done_count: got %0d want 1", fd_cnt); end
    nchk++; if (frame_count !== 16'd2) begin nfail++; $display("FAIL gaps_frame_count: got %0d want 2", frame_count); end
  endtask

  task automatic test_short();
    clear_log();
    pulse_start();
    for (int b = 0; b < 5; b++) send_beat(mk(3, b), b == 4, '1);
    repeat (2) @(negedge clk);
    nchk++; if (w_addr.size() !== 5) begin nfail++; $display("FAIL short_write_count: got %0d want 5", w_addr.size()); end
    for (int i = 0; i < 5 && i < w_addr.size(); i++) begin
      nchk++; if (w_addr[i] !== 4'(i)) begin nfail++; $display("FAIL short_addr[%0d]: got %0d want %0d", i, w_addr[i], i); end
      nchk++; if (w_data[i] !== mk(3, i)) begin nfail++; $display("FAIL short_data[%0d]: got %h want %h", i, w_data[i], mk(3, i)); end
    end
    nchk++; if (err_short !== 1'b1) begin nfail++; $display("FAIL short_err_short: got %b want 1", err_short); end
    nchk++; if (err_long !== 1'b0)  begin nfail++; $display("FAIL short_err_long: got %b want 0", err_long); end
    nchk++; if (fd_cnt !== 0) begin nfail++; $display("FAIL short_done_count: got %0d want 0", fd_cnt); end
    nchk++; if (frame_count !== 16'd2) begin nfail++; $display("FAIL short_frame_count: got %0d want 2", frame_count); end
    nchk++; if ({busy, s_tready} !== 2'b00) begin nfail++; $display("FAIL short_back_idle: busy/tready %b want 00", {busy, s_tready}); end
  endtask

  task automatic test_long();
    clear_log();
    pulse_start();
    nchk++; if (err_short !== 1'b0) begin nfail++; $display("FAIL long_err_short_cleared: got %b want 0", err_short); end
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL long_busy_recv: got %b want 1", busy); end
    for (int b = 0; b < 11; b++) begin
      send_beat(mk(4, b), b == 10, '1);
      if (b == 7) begin
        nchk++; if ({busy, s_tready} !== 2'b11) begin nfail++; $display("FAIL long_drain_busy: busy/tready %b want 11", {busy, s_tready}); end
      end
    end
    repeat (2) @(negedge clk);
    nchk++; if (a_cyc.size() !== 11) begin nfail++; $display("FAIL long_accepts: got %0d want 11", a_cyc.size()); end
    nchk++; if (w_addr.size() !== 8) begin nfail++; $display("FAIL long_write_count: got %0d want 8", w_addr.size()); end
    for (int i = 0; i < 8 && i < w_addr.size(); i++) begin
      nchk++; if (w_addr[i] !== 4'(i)) begin nfail++; $display("FAIL long_addr[%0d]: got %0d want %0d", i, w_addr[i], i); end
      nchk++; if (w_data[i] !== mk(4, i)) begin nfail++; $display("FAIL long_data[%0d]: got %h want %h", i, w_data[i], mk(4, i)); end
    end
    nchk++; if (err_long !== 1'b1)  begin nfail++; $display("FAIL long_err_long: got %b want 1", err_long); end
    nchk++; if (err_short !== 1'b0) begin nfail++; $display("FAIL long_err_short: got %b want 0", err_short); end
    nchk++; if (fd_cnt !== 0) begin nfail++; $display("FAIL long_done_count: got %0d want 0", fd_cnt); end
    nchk++; if (frame_count !== 16'd2) begin nfail++; $display("FAIL long_frame_count: got %0d want 2", frame_count); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL long_back_idle: got %b want 0", busy); end
  endtask

  task automatic test_keep();
    int exp_a[7] = '{0, 1, 3, 4, 5, 6, 7};
    clear_log();
    pulse_start();
    nchk++; if (err_long !== 1'b0) begin nfail++; $display("FAIL keep_err_long_cleared: got %b want 0", err_long); end
    for (int b = 0; b < 8; b++) send_beat(mk(5, b), b == 7, (b == 2) ? 18'h0FFFF : 18'h3FFFF);
    repeat (2) @(negedge clk);
    nchk++; if (w_addr.size() !== 7) begin nfail++; $display("FAIL keep_write_count: got %0d want 7", w_addr.size()); end
    for (int i = 0; i < 7 && i < w_addr.size(); i++) begin
      nchk++; if (w_addr[i] !== 4'(exp_a[i])) begin nfail++; $display("FAIL keep_addr[%0d]: got %0d want %0d", i, w_addr[i], exp_a[i]); end
      nchk++; if (w_data[i] !== mk(5, exp_a[i])) begin nfail++; $display("FAIL keep_data[%0d]: got %h want %h", i, w_data[i], mk(5, exp_a[i])); end
      nchk++; if (w_cyc[i] !== a_cyc[exp_a[i]]) begin nfail++; $display("FAIL keep_write_cycle[%0d]: got %0d want %0d", i, w_cyc[i], a_cyc[exp_a[i]]); end
    end
    nchk++; if (err_keep !== 1'b1) begin nfail++; $display("FAIL keep_err_keep: got %b want 1", err_keep); end
    nchk++; if (fd_cnt !== 1) begin nfail++; $display("FAIL keep_done_count: got %0d want 1", fd_cnt); end
    nchk++; if (frame_count !== 16'd3) begin nfail++; $display("FAIL keep_frame_count: got %0d want 3", frame_count); end
  endtask

  task automatic test_big_and_reset();
    int cnt_after;
    b_frame_start = 1'b1;
    @(negedge clk);
    b_frame_start = 1'b0;
    for (int b = 0; b < 2500; b++) begin
      b_s_tdata = mk(6, b); b_s_tlast = (b == 2499); b_s_tvalid = 1'b1;
      @(negedge clk);
    end
    b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
    repeat (2) @(negedge clk);
    nchk++; if (b_wr_cnt !== 2500) begin nfail++; $display("FAIL big_write_count: got %0d want 2500", b_wr_cnt); end
    nchk++; if (b_fd_cnt !== 1) begin nfail++; $display("FAIL big_done_count: got %0d want 1", b_fd_cnt); end
    nchk++; if (b_fd_addr !== 12'd2499) begin nfail++; $display("FAIL big_done_addr: got %0d want 2499", b_fd_addr); end
    nchk++; if (b_frame_count !== 16'd1) begin nfail++; $display("FAIL big_frame_count: got %0d want 1", b_frame_count); end

    b_frame_start = 1'b1;
    @(negedge clk);
    b_frame_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      b_s_tdata = mk(7, b); b_s_tvalid = 1'b1;
      @(negedge clk);
    end
    b_s_tdata = mk(7, 3);
    b_rst = 1'b1;
    #1;
    nchk++; if ({b_s_tready, b_busy, b_wr_en} !== 3'b000)
      begin nfail++; $display("FAIL big_async_rst: tready/busy/wr_en %b want 000", {b_s_tready, b_busy, b_wr_en}); end
    @(negedge clk);
    b_rst = 1'b0; b_s_tvalid = 1'b0;
    cnt_after = b_wr_cnt;
    @(negedge clk);
    nchk++; if ({b_s_tready, b_busy, b_wr_en, b_frame_done} !== 4'b0000)
      begin nfail++; $display("FAIL big_rst_ctrl: tready/busy/wr_en/done %b want 0000", {b_s_tready, b_busy, b_wr_en, b_frame_done}); end
    nchk++; if (b_frame_count !== 16'd0) begin nfail++; $display("FAIL big_rst_frame_count: got %0d want 0", b_frame_count); end
    nchk++; if (b_wr_addr !== 12'd0) begin nfail++; $display("FAIL big_rst_wr_addr: got %0d want 0", b_wr_addr); end
    nchk++; if ({b_wr_n, b_wr_null, b_wr_ne, b_wr_e, b_wr_se, b_wr_s, b_wr_sw, b_wr_w, b_wr_nw} !== 144'd0)
      begin nfail++; $display("FAIL big_rst_wr_data: got nonzero want 0"); end
    nchk++; if ({b_err_short, b_err_long, b_err_keep} !== 3'b000)
      begin nfail++; $display("FAIL big_rst_err: got %b want 000", {b_err_short, b_err_long, b_err_keep}); end
    b_s_tvalid = 1'b1; b_s_tlast = 1'b1;
    repeat (4) @(negedge clk);
    b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
    @(negedge clk);
    nchk++; if (b_wr_cnt !== cnt_after) begin nfail++; $display("FAIL big_no_write_after_rst: got %0d want %0d", b_wr_cnt, cnt_after); end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; s_tkeep = '1;
    b_rst = 1'b1; b_frame_start = 1'b0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
    b_s_tdata = '0; b_s_tkeep = '1;
    fd_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_stall();
    test_full_frame();
    test_gaps();
    test_short();
    test_long();
    test_keep();
    test_big_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
